// File: rtl/mem_pkg.sv
// mem_pkg: buffer-memory addressing shared by the queueing blocks
package mem_pkg;
  localparam int ADDR_W = 8;
endpackage

// File: rtl/voq_pkg.sv
// voq_pkg: virtual output queue types, depth and occupancy width
package voq_pkg;
  localparam int VOQ_DEPTH = 4;
  localparam int VOQ_CNT_W = $clog2(VOQ_DEPTH + 1);
  typedef enum logic [1:0] {STATE_EMPTY, STATE_NORMAL, STATE_FULL} voq_state_t;
  typedef struct packed {
    logic [mem_pkg::ADDR_W-1:0] ptr;
    logic                       flood;
  } voq_entry_t;
endpackage

// File: rtl/voq_fifo.sv
// voq_fifo: one pointer queue with EMPTY/NORMAL/FULL FSM, empty bypass and drop flag
module voq_fifo
  import voq_pkg::*;
#(
  parameter int DEPTH = VOQ_DEPTH,
  parameter int CNT_W = VOQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             rd,
  input  voq_entry_t       din,
  output voq_entry_t       dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic             drop,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  voq_state_t state, state_n;
  voq_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CNT_W-1:0] cnt_n;
  logic bypass, do_wr, do_rd;
  always_comb begin
    bypass = (state == STATE_EMPTY) && we && rd;
    do_rd = rd && (state != STATE_EMPTY);
    do_wr = we && !bypass && ((state != STATE_FULL) || rd);
    cnt_n = count + CNT_W'(do_wr) - CNT_W'(do_rd);
    state_n = cnt_n == CNT_W'(DEPTH) ? STATE_FULL : cnt_n == '0 ? STATE_EMPTY : STATE_NORMAL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_EMPTY;
      count <= '0;
      wp <= '0;
      rp <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      count <= cnt_n;
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      dout_valid <= bypass || do_rd;
      drop <= we && !rd && (state == STATE_FULL);
      if (bypass) dout <= din;
      else if (do_rd) dout <= mem[rp];
    end
  end
  // when full, the slot being written is the one read this cycle; the read sees the old entry
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= din;
  end
  assign empty = state == STATE_EMPTY;
  assign full = state == STATE_FULL;
endmodule

// File: rtl/voq_bank.sv
// voq_bank: NUM_Q independent pointer queues with masked multicast write.
// VOQ_BANK_STATS_EN adds saturating per-queue drop counters on drop_cnt_o.
module voq_bank
  import voq_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int DEPTH = VOQ_DEPTH,
  parameter int ADDR_W = mem_pkg::ADDR_W,
`ifdef VOQ_BANK_STATS_EN
  parameter int STAT_W = 16,
`endif
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid_i,
  input  logic [NUM_Q-1:0]        wr_mask_i,
  input  logic [ADDR_W-1:0]       ptr_i,
  input  logic                    flood_i,
  input  logic [NUM_Q-1:0]        rd_req_i,
  output logic [NUM_Q*ADDR_W-1:0] ptr_o,
  output logic [NUM_Q-1:0]        flood_o,
  output logic [NUM_Q-1:0]        ptr_valid_o,
  output logic [NUM_Q-1:0]        empty_o,
  output logic [NUM_Q-1:0]        full_o,
  output logic [NUM_Q*CNT_W-1:0]  count_o,
`ifdef VOQ_BANK_STATS_EN
  output logic [NUM_Q*STAT_W-1:0] drop_cnt_o,
`endif
  output logic [NUM_Q-1:0]        drop_o
);
  logic [NUM_Q-1:0] we;
  voq_entry_t din;
  voq_entry_t dout [NUM_Q];
  assign we = {NUM_Q{wr_valid_i}} & wr_mask_i;
  assign din = '{ptr: ptr_i, flood: flood_i};
  for (genvar i = 0; i < NUM_Q; i++) begin : g_q
    logic [CNT_W-1:0] cnt;
    voq_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk(clk), .rst(rst), .we(we[i]), .rd(rd_req_i[i]), .din(din),
      .dout(dout[i]), .dout_valid(ptr_valid_o[i]), .empty(empty_o[i]),
      .full(full_o[i]), .drop(drop_o[i]), .count(cnt)
    );
    assign ptr_o[i*ADDR_W +: ADDR_W] = dout[i].ptr;
    assign flood_o[i] = dout[i].flood;
    assign count_o[i*CNT_W +: CNT_W] = cnt;
`ifdef VOQ_BANK_STATS_EN
    logic [STAT_W-1:0] drop_cnt;
    always_ff @(posedge clk) begin
      if (rst) drop_cnt <= '0;
      else if (drop_o[i] && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
    assign drop_cnt_o[i*STAT_W +: STAT_W] = drop_cnt;
`endif
  end
endmodule

// File: tb/tb_voq_bank.sv
// tb_voq_bank: directed and random checks of voq_bank against a queue-based reference model
module tb_voq_bank;
  logic clk, rst, wr_valid_i, flood_i;
  logic [3:0] wr_mask_i, rd_req_i, flood_o, ptr_valid_o, empty_o, full_o, drop_o;
  logic [7:0] ptr_i;
  logic [31:0] ptr_o;
  logic [11:0] count_o;
`ifdef VOQ_BANK_STATS_EN
  logic [63:0] drop_cnt_o;
`endif
  voq_bank #(.NUM_Q(4), .DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .wr_valid_i(wr_valid_i), .wr_mask_i(wr_mask_i),
    .ptr_i(ptr_i), .flood_i(flood_i), .rd_req_i(rd_req_i), .ptr_o(ptr_o),
    .flood_o(flood_o), .ptr_valid_o(ptr_valid_o), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o),
`ifdef VOQ_BANK_STATS_EN
    .drop_cnt_o(drop_cnt_o),
`endif
    .drop_o(drop_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [8:0] qm [4][$];
  logic [7:0] ep [4];
  logic ef [4];
  logic [3:0] ev, ed;
  int dcnt [4];
  int vecs, errs;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic check_all();
    logic [31:0] xp;
    logic [11:0] xc;
    logic [3:0] xe, xf, xfl;
    logic [63:0] xd;
    for (int q = 0; q < 4; q++) begin
      xp[q*8 +: 8] = ep[q];
      xfl[q] = ef[q];
      xc[q*3 +: 3] = 3'(qm[q].size());
      xe[q] = qm[q].size() == 0;
      xf[q] = qm[q].size() == 4;
      xd[q*16 +: 16] = 16'(dcnt[q]);
    end
    chk("ptr_valid", ptr_valid_o, ev);
    chk("drop", drop_o, ed);
    chk("ptr", ptr_o, xp);
    chk("flood", flood_o, xfl);
    chk("empty", empty_o, xe);
    chk("full", full_o, xf);
    chk("count", count_o, xc);
`ifdef VOQ_BANK_STATS_EN
    chk("drop_cnt", drop_cnt_o, xd);
`endif
  endtask
  task automatic step(input logic v, input logic [3:0] m, input logic [7:0] p, input logic f, input logic [3:0] r);
    logic [8:0] e;
    logic w;
    wr_valid_i = v; wr_mask_i = m; ptr_i = p; flood_i = f; rd_req_i = r;
    @(posedge clk);
    for (int q = 0; q < 4; q++) begin
      if (ed[q] && dcnt[q] < 65535) dcnt[q]++;
      w = v & m[q];
      ev[q] = 1'b0;
      ed[q] = 1'b0;
      if (qm[q].size() == 0) begin
        if (w && r[q]) begin
          ev[q] = 1'b1; ep[q] = p; ef[q] = f;
        end else if (w) qm[q].push_back({f, p});
      end else begin
        if (w && qm[q].size() == 4 && !r[q]) ed[q] = 1'b1;
        else if (w && r[q]) qm[q].push_back({f, p});
        if (r[q]) begin
          e = qm[q].pop_front();
          ev[q] = 1'b1; ep[q] = e[7:0]; ef[q] = e[8];
        end
        if (w && !r[q] && !ed[q]) qm[q].push_back({f, p});
      end
    end
    #1;
    check_all();
  endtask
  task automatic rst_step();
    rst = 1'b1;
    wr_valid_i = 1'b0; wr_mask_i = '0; ptr_i = '0; flood_i = 1'b0; rd_req_i = '0;
    @(posedge clk);
    for (int q = 0; q < 4; q++) begin
      qm[q].delete();
      ep[q] = '0; ef[q] = 1'b0; dcnt[q] = 0;
    end
    ev = '0; ed = '0;
    #1;
    check_all();
    rst = 1'b0;
  endtask
  initial begin
    vecs = 0; errs = 0;
    rst_step();
    chk("t1_empty", empty_o, 4'hF);
    step(0, 4'h0, 8'h00, 0, 4'hF);
    chk("t1_novalid", ptr_valid_o, 4'h0);
    step(1, 4'h1, 8'h11, 0, 4'h0);
    step(1, 4'h1, 8'h22, 0, 4'h0);
    step(1, 4'h1, 8'h33, 0, 4'h0);
    step(0, 4'h0, 8'h00, 0, 4'h1);
    chk("t2_r0", ptr_o[7:0], 8'h11);
    step(0, 4'h0, 8'h00, 0, 4'h1);
    chk("t2_r1", ptr_o[7:0], 8'h22);
    step(0, 4'h0, 8'h00, 0, 4'h1);
    chk("t2_r2", ptr_o[7:0], 8'h33);
    chk("t2_empty", empty_o[0], 1'b1);
    for (int i = 0; i < 4; i++) step(1, 4'h2, 8'hA0 + 8'(i), 0, 4'h0);
    chk("t3_full", full_o[1], 1'b1);
    chk("t3_count", count_o[5:3], 3'd4);
    step(1, 4'h2, 8'hA4, 0, 4'h0);
    chk("t3_drop", drop_o, 4'h2);
    step(1, 4'h2, 8'hB0, 0, 4'h2);
    chk("t4_ptr", ptr_o[15:8], 8'hA0);
    chk("t4_nodrop", drop_o, 4'h0);
    chk("t4_count", count_o[5:3], 3'd4);
    for (int i = 1; i < 4; i++) begin
      step(0, 4'h0, 8'h00, 0, 4'h2);
      chk("t3_rd", ptr_o[15:8], 8'hA0 + 8'(i));
    end
    step(0, 4'h0, 8'h00, 0, 4'h2);
    chk("t4_last", ptr_o[15:8], 8'hB0);
    step(1, 4'h4, 8'h5C, 0, 4'h4);
    chk("t5_ptr", ptr_o[23:16], 8'h5C);
    chk("t5_valid", ptr_valid_o, 4'h4);
    chk("t5_empty", empty_o[2], 1'b1);
    for (int i = 0; i < 4; i++) step(1, 4'h8, 8'hC0 + 8'(i), 0, 4'h0);
    step(1, 4'hD, 8'h77, 1, 4'h0);
    chk("t6_drop", drop_o, 4'h8);
    step(0, 4'h0, 8'h00, 0, 4'h5);
    chk("t6_ptr0", ptr_o[7:0], 8'h77);
    chk("t6_ptr2", ptr_o[23:16], 8'h77);
    chk("t6_flood", flood_o & 4'h5, 4'h5);
    for (int i = 0; i < 1000; i++) begin
      if (i == 600) rst_step();
      else step($urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom), 1'($urandom),
                4'($urandom) & 4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
